// File: rtl/mem_arb.sv
// mem_arb -- two-port arbiter in front of a single synchronous memory.
//
// Port 0 (processor) and port 1 (loader/debug) compete for one shared memory
// port. Ties alternate between the ports, except that the current owner may
// keep the memory for back-to-back beats by holding its lock, up to HOLD_MAX
// consecutive beats while the other port waits.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   req*/we*/lock*          per-port request, write enable, hold request
//   addr*/wdata*            per-port word address and write data
//   gnt*                    combinational grant (beat = req & gnt)
//   rvalid*/rdata*          read data valid one cycle after a granted read
//   mem_addr/wdata/we       shared memory request (zero when no grant)
//   mem_rdata               synchronous memory read data
//   owner                   registered arbiter state (00 idle, 01/10 owner)

module mem_arb #(
   parameter int HOLD_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic        lock0,
   input  logic        lock1,
   input  logic [6:0]  addr0,
   input  logic [6:0]  addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic [6:0]  mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   output logic [1:0]  owner
);

   localparam logic [2:0] HOLD_LIM = 3'(HOLD_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t     state;
   logic       last;   // last granted port
   logic [2:0] cnt;    // consecutive beats won by 'last'

   logic any_req;
   logic lock_last;
   logic hold;
   logic win;          // winning port, meaningful only when any_req

   // Arbitration
   always_comb begin
      any_req   = req0 | req1;
      lock_last = last ? lock1 : lock0;
      // The owner keeps the memory on a tie only while it is locking and
      // has not yet used up its hold budget.
      hold      = lock_last && (state != IDLE) && (cnt < HOLD_LIM);
      if (req0 && !req1)
         win = 1'b0;
      else if (req1 && !req0)
         win = 1'b1;
      else
         win = hold ? last : ~last;
   end

   // Grants are suppressed during reset so nothing reaches the memory.
   assign gnt0 = reset & any_req & ~win;
   assign gnt1 = reset & any_req &  win;

   // Shared memory port mux
   always_comb begin
      mem_addr  = 7'd0;
      mem_wdata = 16'd0;
      mem_we    = 1'b0;
      if (gnt0) begin
         mem_addr  = addr0;
         mem_wdata = wdata0;
         mem_we    = we0;
      end else if (gnt1) begin
         mem_addr  = addr1;
         mem_wdata = wdata1;
         mem_we    = we1;
      end
   end

   // State, hold counter and read-valid pipeline
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         last    <= 1'b1;   // so port 0 wins the first tie
         cnt     <= 3'd0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= gnt0 & ~we0;
         rvalid1 <= gnt1 & ~we1;
         if (any_req) begin
            last  <= win;
            state <= win ? OWN1 : OWN0;
            if ((win == last) && (state != IDLE))
               cnt <= (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
            else
               cnt <= 3'd1;
         end else begin
            state <= IDLE;
            cnt   <= 3'd0;
         end
      end
   end

   assign owner  = state;
   assign rdata0 = mem_rdata;
   assign rdata1 = mem_rdata;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb -- directed vectors for mem_arb with a small synchronous memory
// model behind the shared port. Inputs change on the falling edge, outputs
// are sampled 1 ns later.

module tb_mem_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [6:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [15:0] rdata0, rdata1;
   logic [6:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic [1:0]  owner;

   int n_vec = 0;
   int n_err = 0;
   logic exp_rv0 = 1'b0;
   logic exp_rv1 = 1'b0;

   logic [15:0] mem [0:127];

   mem_arb #(.HOLD_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   // Synchronous memory: read data one cycle after the address
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: apply inputs, check grant, memory port and rvalid from the
   // previous beat; then record which rvalid the next cycle should show.
   task automatic beat(input string tag,
                       input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic l0, input logic l1,
                       input logic [6:0] a0, input logic [6:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic eg0, input logic eg1);
      logic [6:0]  ea;
      logic [15:0] ed;
      logic        ew;
      @(negedge clk);
      req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      #1;
      ea = eg0 ? a0 : (eg1 ? a1 : 7'd0);
      ed = eg0 ? d0 : (eg1 ? d1 : 16'd0);
      ew = eg0 ? w0 : (eg1 ? w1 : 1'b0);
      chk({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
      chk({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ea));
      chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(ed));
      chk({tag, ".mem_we"}, 32'(mem_we), 32'(ew));
      chk({tag, ".rvalid0"}, 32'(rvalid0), 32'(exp_rv0));
      chk({tag, ".rvalid1"}, 32'(rvalid1), 32'(exp_rv1));
      exp_rv0 = eg0 & ~w0;
      exp_rv1 = eg1 & ~w1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] lock_pat;
      for (int i = 0; i < 128; i++) mem[i] = 16'(i * 3);
      mem[5] = 16'hBEEF;

      // Reset held from time 0, with a write request pending
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b0; we0 = 1'b1; we1 = 1'b0;
      lock0 = 1'b0; lock1 = 1'b0;
      addr0 = 7'h10; addr1 = 7'h00; wdata0 = 16'hAAAA; wdata1 = 16'h0;
      @(negedge clk); #1;
      chk("rst.owner", 32'(owner), 32'h0);
      chk("rst.gnt0", 32'(gnt0), 32'h0);
      chk("rst.mem_we", 32'(mem_we), 32'h0);
      chk("rst.rvalid0", 32'(rvalid0), 32'h0);
      chk("rst.cnt", 32'(dut.cnt), 32'h0);
      @(negedge clk);
      reset = 1'b1; req0 = 1'b0; we0 = 1'b0;

      // Solo read of memory[5]
      beat("rd5a", 1, 0, 0, 0, 0, 0, 7'h05, 7'h00, 16'h0, 16'h0, 1, 0);
      beat("rd5b", 1, 0, 0, 0, 0, 0, 7'h05, 7'h00, 16'h0, 16'h0, 1, 0);
      chk("rd5.rdata0", 32'(rdata0), 32'hBEEF);
      chk("rd5.owner", 32'(owner), 32'h1);

      // Reset pulse mid-cycle while port 0 is still requesting
      #1 reset = 1'b0;
      #1;
      chk("pulse.owner", 32'(owner), 32'h0);
      chk("pulse.rvalid0", 32'(rvalid0), 32'h0);
      chk("pulse.gnt0", 32'(gnt0), 32'h0);
      chk("pulse.mem_we", 32'(mem_we), 32'h0);
      exp_rv0 = 1'b0; exp_rv1 = 1'b0;

      // Release with both requesting: port 0 wins, then strict alternation
      @(negedge clk);
      reset = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 7'h11; addr1 = 7'h22;
      #1;
      chk("rel.gnt0", 32'(gnt0), 32'h1);
      chk("rel.gnt1", 32'(gnt1), 32'h0);
      chk("rel.mem_addr", 32'(mem_addr), 32'h11);
      exp_rv0 = 1'b1;
      for (int k = 1; k < 6; k++)
         beat($sformatf("rr%0d", k), 1, 1, 0, 0, 0, 0, 7'h11, 7'h22, 16'h0, 16'h0,
              (k % 2) == 0, (k % 2) == 1);

      // Idle cycle: everything parks at zero
      beat("idle1", 0, 0, 0, 0, 0, 0, 7'h11, 7'h22, 16'h0, 16'h0, 0, 0);

      // Port 0 locks from idle: four beats, one for port 1, then port 0
      lock_pat = 6'b010000;   // bit k = 1 means port 1 wins cycle k
      for (int k = 0; k < 6; k++)
         beat($sformatf("lock%0d", k), 1, 1, 0, 0, 1, 0, 7'h33, 7'h44, 16'h0, 16'h0,
              !lock_pat[k], lock_pat[k]);
      beat("idle2", 0, 0, 0, 0, 0, 0, 7'h00, 7'h00, 16'h0, 16'h0, 0, 0);

      // Port 1 write, then read back the same word
      beat("wr7f", 0, 1, 0, 1, 0, 0, 7'h00, 7'h7F, 16'h0, 16'h1234, 0, 1);
      beat("rd7f", 0, 1, 0, 0, 0, 0, 7'h00, 7'h7F, 16'h0, 16'h0, 0, 1);

      // Port 0 alone for 10 beats; a stray lock1 without req1 is ignored
      for (int k = 0; k < 10; k++) begin
         beat($sformatf("sat%0d", k), 1, 0, 0, 0, 0, 1, 7'h05, 7'h00, 16'h0, 16'h0, 1, 0);
         if (k == 0) chk("rd7f.rdata1", 32'(rdata1), 32'h1234);
      end
      beat("drop", 0, 0, 0, 0, 0, 0, 7'h05, 7'h00, 16'h0, 16'h0, 0, 0);
      chk("sat.cnt", 32'(dut.cnt), 32'h7);
      chk("drop.owner_pre", 32'(owner), 32'h1);
      @(negedge clk); #1;
      chk("drop.owner", 32'(owner), 32'h0);
      chk("drop.cnt", 32'(dut.cnt), 32'h0);
      chk("drop.mem_addr", 32'(mem_addr), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 4: maximum consecutive beats one port may hold the memory while the other port waits; legal range 1..7.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0, req1  input  1 each  access request, port 0 (processor) and port 1 (loader/debug).
REQ-005 SHALL have ports we0, we1  input  1 each  1 = write, 0 = read; qualified by req.
REQ-006 SHALL have ports lock0, lock1  input  1 each  owner asks to keep the grant for back-to-back beats.
REQ-007 SHALL have ports addr0, addr1  input  7 each  word address.
REQ-008 SHALL have ports wdata0, wdata1  input  16 each  write data.
REQ-009 SHALL have ports gnt0, gnt1  output  1 each  combinational grant; a beat completes on a cycle with req & gnt.
REQ-010 SHALL have ports rvalid0, rvalid1  output  1 each  registered read-data-valid.
REQ-011 SHALL have ports rdata0, rdata1  output  16 each  read data, equal to mem_rdata.
REQ-012 SHALL have ports mem_addr  output  7, mem_wdata  output  16, mem_we  output  1  shared memory port.
REQ-013 SHALL have port mem_rdata  input  16  synchronous memory read data, valid one cycle after the address.
REQ-014 SHALL have port owner  output  2  registered FSM state: 00 IDLE, 01 OWN0, 10 OWN1.

Function
REQ-015 SHALL keep state registers: FSM state (IDLE/OWN0/OWN1), last (1 bit, last-granted port) and cnt (3 bits, consecutive-beat count).
REQ-016 SHALL assert at most one of gnt0/gnt1 in any cycle, and never assert gnt without the matching req.
REQ-017 SHALL compute the winner combinationally from req, lock and the registered state, as follows.
REQ-018 If exactly one req is high, that port SHALL win, regardless of lock or cnt.
REQ-019 If both are high, port last SHALL win when lock[last] = 1, the state is not IDLE and cnt < HOLD_MAX; otherwise port ~last SHALL win.
REQ-020 When both are high and the FSM is in IDLE, port ~last SHALL win; after reset this is port 0.
REQ-021 On a granted cycle, the block SHALL set last to the winner and move the FSM to OWN<winner>.
REQ-022 On a granted cycle, cnt SHALL become min(cnt+1, 7) if the winner equals last and the state is not IDLE, else 1.
REQ-023 On a cycle with no req, the FSM SHALL go to IDLE with cnt = 0 and last unchanged.
REQ-024 mem_addr, mem_wdata and mem_we SHALL carry the winner's addr, wdata and we in the same cycle.
REQ-025 With no grant, mem_addr SHALL be 0, mem_wdata 0 and mem_we 0.
REQ-026 rvalidk SHALL be 1 in the cycle after a granted read beat (reqk & gntk & ~wek) and 0 otherwise; read latency is exactly 1 cycle.
REQ-027 rdata0 and rdata1 SHALL both equal mem_rdata and are meaningful only while the matching rvalid is high.
REQ-028 A write beat SHALL produce no rvalid.
REQ-029 Back-to-back beats SHALL be supported at one beat per cycle, with no idle cycle on an owner switch.
REQ-030 A lock with its req low SHALL be ignored.
REQ-031 Deasserting lock SHALL take effect in the same cycle's arbitration.
REQ-032 cnt SHALL saturate at 7 and SHALL never wrap to 0 while a port keeps winning.

Reset
REQ-033 When reset is low, the block SHALL immediately set state = IDLE, last = 1, cnt = 0, rvalid0 = rvalid1 = 0 and owner = 00, independent of clk.
REQ-034 A read granted in the cycle reset asserts SHALL produce no rvalid; the first arbitration after reset release SHALL favour port 0 on a tie.
REQ-035 While reset is low, gnt0/gnt1 SHALL be 0 and mem_we SHALL be 0.

Verification
REQ-036 Reset: pulse reset low mid-cycle with req0 = 1 -> owner = 00 and rvalid0 = 0 asynchronously; after release, req0 = req1 = 1 gives gnt0 = 1 in the first cycle.
REQ-037 Solo read: req0 = 1, we0 = 0, addr0 = 7'h05, memory[5] = 16'hBEEF -> gnt0 = 1, mem_addr = 05; next cycle rvalid0 = 1, rdata0 = BEEF, rvalid1 = 0.
REQ-038 Round-robin: req0 = req1 = 1, no lock, 6 cycles -> grants 0,1,0,1,0,1 with mem_addr alternating between addr0 and addr1 each cycle.
REQ-039 Lock limit: HOLD_MAX = 4, lock0 = 1, req0 = req1 = 1 from IDLE -> gnt0 for 4 cycles, then gnt1 for 1 cycle, then gnt0 again.
REQ-040 Write path: req1 = 1, we1 = 1, addr1 = 7'h7F, wdata1 = 16'h1234 -> mem_we = 1, mem_addr = 7F, mem_wdata = 1234; next cycle rvalid1 = 0.
REQ-041 Idle/saturation: req0 alone for 10 cycles -> gnt0 every cycle and cnt holds at 7; then drop req0 -> owner = 00, mem_addr = 0, mem_we = 0.
